// File: rtl/axi_lite_ram.sv
// AXI4-Lite single-port word RAM slave with independent AW/W capture,
// configurable read wait states and a registered out-of-range pulse.
module axi_lite_ram #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] AWdata,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [2:0]  AWprot,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  input  logic        Wvalid,
  output logic        Wready,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic [31:0] ARdata,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [2:0]  ARprot,
  output logic [31:0] Rdata,
  output logic        Rvalid,
  input  logic        RReady,
  output logic        decode_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_RESP, RD_WAIT, RD_DATA} state_e;

  // 33-bit compare so a window ending at 2^32 cannot wrap.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, a} <  ({1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS)));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   aw_addr_q, w_data_q;
  logic [3:0]    w_strb_q;
  logic          aw_held_q, w_held_q;
  logic [AW-1:0] rd_idx_q;
  logic          rd_ok_q;
  logic [3:0]    wait_cnt_q;
  logic [31:0]   rdata_q;
  logic          decode_err_q;
  logic [31:0]   mem_q [MEM_WORDS];

  logic          wr_accept, aw_hs, w_hs, ar_hs, wr_fire, rd_load;
  logic [31:0]   wr_addr, wr_data;
  logic [3:0]    wr_strb;
  logic [AW-1:0] rd_src_idx;
  logic          rd_src_ok;
  logic          unused_prot;

  assign unused_prot = ^{AWprot, ARprot};

  assign wr_accept = (state_q == IDLE) || (state_q == WR_COLLECT);
  assign AWready   = rstn & wr_accept & ~aw_held_q;
  assign Wready    = rstn & wr_accept & ~w_held_q;
  assign ARready   = rstn & (state_q == IDLE) & ~AWvalid & ~Wvalid;

  assign aw_hs = AWvalid & AWready;
  assign w_hs  = Wvalid & Wready;
  assign ar_hs = ARvalid & ARready;

  // A channel arriving this cycle is used directly so both-at-once costs no extra cycle.
  assign wr_addr = aw_held_q ? aw_addr_q : AWdata;
  assign wr_data = w_held_q  ? w_data_q  : Wdata;
  assign wr_strb = w_held_q  ? w_strb_q  : Wstrb;
  assign wr_fire = wr_accept & (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign rd_src_idx = (state_q == IDLE) ? word_idx(ARdata) : rd_idx_q;
  assign rd_src_ok  = (state_q == IDLE) ? in_range(ARdata) : rd_ok_q;
  assign rd_load    = ((state_q == IDLE) && ar_hs && (WAIT_STATES == 0)) ||
                      ((state_q == RD_WAIT) && (wait_cnt_q == 4'd0));

  assign Bvalid     = (state_q == WR_RESP);
  assign Rvalid     = (state_q == RD_DATA);
  assign Rdata      = rdata_q;
  assign decode_err = decode_err_q;

  // NOTE: next state defaults to the current state first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_fire)             state_d = WR_RESP;
        else if (aw_hs || w_hs)  state_d = WR_COLLECT;
        else if (ar_hs)          state_d = (WAIT_STATES == 0) ? RD_DATA : RD_WAIT;
      end
      WR_COLLECT: if (wr_fire)               state_d = WR_RESP;
      WR_RESP:    if (Bready)                state_d = IDLE;
      RD_WAIT:    if (wait_cnt_q == 4'd0)    state_d = RD_DATA;
      RD_DATA:    if (RReady)                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      rd_idx_q     <= '0;
      rd_ok_q      <= 1'b0;
      wait_cnt_q   <= '0;
      rdata_q      <= '0;
      decode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      decode_err_q <= (wr_fire & ~in_range(wr_addr)) | (rd_load & ~rd_src_ok);
      if (aw_hs) begin
        aw_addr_q <= AWdata;
        aw_held_q <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= Wdata;
        w_strb_q <= Wstrb;
        w_held_q <= 1'b1;
      end
      if ((state_q == WR_RESP) && Bready) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (ar_hs) begin
        rd_idx_q   <= word_idx(ARdata);
        rd_ok_q    <= in_range(ARdata);
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == RD_WAIT) && (wait_cnt_q != 4'd0)) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if (rd_load) rdata_q <= rd_src_ok ? mem_q[rd_src_idx] : 32'h0;
    end
  end

  // NOTE: the array has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range(wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem_q[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
